// File: rtl/wb_sram_slave.sv
// Wishbone classic slave that turns tagged 8-bit bus cycles into async SRAM accesses
// with programmable read wait states and write-enable pulse width.
module wb_sram_slave #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned WAIT_RD = 1,
  parameter int unsigned WAIT_WR = 1,
  parameter logic [1:0]  TAG_SEL = 2'b00
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [1:0]        wbs_tga_i,
  input  logic [7:0]        wbs_dat_i,
  output logic [7:0]        wbs_dat_o,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  output logic              wbs_ack_o,
  output logic [ADDR_W-1:0] sram_a_o,
  input  logic [7:0]        sram_dq_i,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  if (WAIT_WR < 1 || WAIT_WR > 15 || WAIT_RD > 15) begin : g_bad_wait
    $error("wb_sram_slave: WAIT_RD must be 0..15 and WAIT_WR 1..15");
  end

  localparam logic [3:0] WAIT_RD4 = WAIT_RD[3:0];
  localparam logic [3:0] WAIT_WR4 = WAIT_WR[3:0];

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                we_q_reg, we_q_next;
  logic                ack_reg, ack_next;
  logic [7:0]          dat_o_reg, dat_o_next;
  logic [ADDR_W-1:0]   a_reg, a_next;
  logic [7:0]          dq_o_reg, dq_o_next;
  logic                dq_oe_reg, dq_oe_next;
  logic                ce_n_reg, ce_n_next;
  logic                oe_n_reg, oe_n_next;
  logic                we_n_reg, we_n_next;

  logic req;
  assign req = wbs_cyc_i & wbs_stb_i & (wbs_tga_i == TAG_SEL);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_q_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      dat_o_reg <= '0;
      a_reg     <= '0;
      dq_o_reg  <= '0;
      dq_oe_reg <= 1'b0;
      ce_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_q_reg  <= we_q_next;
      ack_reg   <= ack_next;
      dat_o_reg <= dat_o_next;
      a_reg     <= a_next;
      dq_o_reg  <= dq_o_next;
      dq_oe_reg <= dq_oe_next;
      ce_n_reg  <= ce_n_next;
      oe_n_reg  <= oe_n_next;
      we_n_reg  <= we_n_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_q_next  = we_q_reg;
    ack_next   = ack_reg;
    dat_o_next = dat_o_reg;
    a_next     = a_reg;
    dq_o_next  = dq_o_reg;
    dq_oe_next = dq_oe_reg;
    ce_n_next  = ce_n_reg;
    oe_n_next  = oe_n_reg;
    we_n_next  = we_n_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = ACCESS;
          a_next     = wbs_adr_i;
          we_q_next  = wbs_we_i;
          ce_n_next  = 1'b0;
          if (wbs_we_i) begin
            dq_o_next  = wbs_dat_i;
            dq_oe_next = 1'b1;
            cnt_next   = WAIT_WR4;
          end else begin
            oe_n_next = 1'b0;
            cnt_next  = WAIT_RD4;
          end
        end
      end
      ACCESS: begin
        // An abort takes priority even when the wait count has just expired.
        if (!wbs_cyc_i) begin
          state_next = IDLE;
          ce_n_next  = 1'b1;
          oe_n_next  = 1'b1;
          we_n_next  = 1'b1;
          dq_oe_next = 1'b0;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
          if (we_q_reg) we_n_next = 1'b0;
        end else begin
          state_next = ACK;
          ack_next   = 1'b1;
          if (we_q_reg) we_n_next = 1'b1;
          else          dat_o_next = sram_dq_i;
        end
      end
      ACK: begin
        state_next = IDLE;
        ack_next   = 1'b0;
        ce_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        we_n_next  = 1'b1;
        dq_oe_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wbs_ack_o    = ack_reg;
  assign wbs_dat_o    = dat_o_reg;
  assign sram_a_o     = a_reg;
  assign sram_dq_o    = dq_o_reg;
  assign sram_dq_oe_o = dq_oe_reg;
  assign sram_ce_n_o  = ce_n_reg;
  assign sram_oe_n_o  = oe_n_reg;
  assign sram_we_n_o  = we_n_reg;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Randomized bench for wb_sram_slave: a simple async SRAM device plus a byte-array
// reference memory and spec-derived latency/strobe-width expectations.
module tb_wb_sram_slave;
  localparam int AW = 19;
  localparam int WRD = 1;
  localparam int WWR = 2;
  localparam int RD_LAT = WRD + 2;
  localparam int WR_LAT = WWR + 2;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [1:0]    tga = 2'b00;
  logic [7:0]    dat_i = '0;
  logic [7:0]    dat_o;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic          ack;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_dq_i, sram_dq_o;
  logic          dq_oe, ce_n, oe_n, we_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_sram_slave #(.ADDR_W(AW), .WAIT_RD(WRD), .WAIT_WR(WWR), .TAG_SEL(2'b00)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .wbs_adr_i(adr), .wbs_tga_i(tga), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_ack_o(ack),
    .sram_a_o(sram_a), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe_o(dq_oe), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n)
  );

  // SRAM device: combinational read, write captured while we_n is low.
  logic [7:0] dev_mem [0:(1<<AW)-1];
  assign sram_dq_i = (!ce_n && !oe_n) ? dev_mem[sram_a] : 8'hFF;
  always @(posedge clk)
    if (!ce_n && !we_n && dq_oe) dev_mem[sram_a] = sram_dq_o;

  // Reference memory, indexed by bus address.
  logic [7:0] ref_mem [int];

  // Per-transfer strobe monitor, sampled on the falling edge.
  int we_low, oe_low, ce_low, oe_cyc, dq_bad, ack_cnt;
  logic [7:0] mon_dq;
  always @(negedge clk) begin
    if (!we_n) we_low++;
    if (!oe_n) oe_low++;
    if (!ce_n) ce_low++;
    if (dq_oe) begin
      oe_cyc++;
      if (sram_dq_o !== mon_dq) dq_bad++;
    end
    if (ack) ack_cnt++;
  end

  task automatic clr_mon(input logic [7:0] dq);
    we_low = 0; oe_low = 0; ce_low = 0; oe_cyc = 0; dq_bad = 0; ack_cnt = 0; mon_dq = dq;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    dev_mem[a] = d;
    ref_mem[int'(a)] = d;
  endtask

  // One bus transfer; lat is the number of edges from the req-sampling edge (counted as 1)
  // to the edge after which ack is seen, 0 on timeout. Ends one edge after the ack.
  task automatic bus_xfer(input logic w, input logic [AW-1:0] a, input logic [7:0] d,
                          input bit scramble, output logic [7:0] rdata, output int lat);
    bit got = 0;
    cyc = 1; stb = 1; tga = 2'b00; we = w; adr = a; dat_i = d;
    lat = 0; rdata = '0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (scramble) begin adr = AW'($urandom); we = 1'($urandom); dat_i = 8'($urandom); end
      if (ack) begin got = 1; lat = k; rdata = dat_o; end
    end
    cyc = 0; stb = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({ack, dat_o, sram_a, sram_dq_o, dq_oe, ce_n, oe_n, we_n} !== {1'b0, 8'h00, 19'h0, 8'h00, 1'b0, 3'b111}) begin
      n_bad++;
      $display("FAIL reset_values: ack=%b dat=%h a=%h dq=%h oe=%b ce_n=%b oe_n=%b we_n=%b, required 0 00 0 00 0 1 1 1",
               ack, dat_o, sram_a, sram_dq_o, dq_oe, ce_n, oe_n, we_n);
    end
    @(posedge clk); #1; nrst = 1;
    @(posedge clk); #1;
    $display("reset: ack=%b ce_n=%b", ack, ce_n);
  endtask

  task automatic test_read;
    logic [7:0] r; int lat;
    preload(19'h12345, 8'hA5);
    clr_mon(8'h00);
    bus_xfer(1'b0, 19'h12345, 8'h00, 1'b0, r, lat);
    n_cmp++; if (lat !== RD_LAT) begin n_bad++; $display("FAIL read_latency: got %0d, required %0d", lat, RD_LAT); end
    n_cmp++; if (r !== 8'hA5) begin n_bad++; $display("FAIL read_data: got %h, required a5", r); end
    n_cmp++; if (sram_a !== 19'h12345) begin n_bad++; $display("FAIL read_addr: got %h, required 12345", sram_a); end
    n_cmp++; if (oe_low !== 3) begin n_bad++; $display("FAIL read_oe_width: got %0d, required 3", oe_low); end
    n_cmp++; if (ack_cnt !== 1 || ack !== 1'b0) begin n_bad++; $display("FAIL read_ack_pulse: got %0d cycles, required 1", ack_cnt); end
    $display("read a=12345 data=%h lat=%0d oe_low=%0d", r, lat, oe_low);
  endtask

  task automatic test_write;
    logic [7:0] r; int lat;
    clr_mon(8'h3C);
    bus_xfer(1'b1, 19'h00456, 8'h3C, 1'b0, r, lat);
    ref_mem[32'h456] = 8'h3C;
    n_cmp++; if (lat !== WR_LAT) begin n_bad++; $display("FAIL write_latency: got %0d, required %0d", lat, WR_LAT); end
    n_cmp++; if (we_low !== WWR) begin n_bad++; $display("FAIL write_we_width: got %0d, required %0d", we_low, WWR); end
    n_cmp++; if (oe_cyc !== WWR + 2 || dq_bad !== 0) begin n_bad++; $display("FAIL write_dq_hold: got %0d cycles (%0d bad), required %0d", oe_cyc, dq_bad, WWR + 2); end
    n_cmp++; if (ack_cnt !== 1) begin n_bad++; $display("FAIL write_ack_pulse: got %0d cycles, required 1", ack_cnt); end
    n_cmp++; if (dev_mem[19'h456] !== 8'h3C) begin n_bad++; $display("FAIL write_sram_data: got %h, required 3c", dev_mem[19'h456]); end
    $display("write a=00456 data=3c lat=%0d we_low=%0d", lat, we_low);
  endtask

  task automatic test_ignored;
    clr_mon(8'h00);
    cyc = 1; stb = 1; tga = 2'b01; we = 0; adr = 19'h00456;
    repeat (10) @(posedge clk);
    #1; tga = 2'b00; cyc = 0;
    repeat (5) @(posedge clk);
    #1; stb = 0;
    @(posedge clk); #1;
    n_cmp++; if (ack_cnt !== 0 || ce_low !== 0) begin n_bad++; $display("FAIL ignored_cycles: got acks=%0d ce_low=%0d, required 0 0", ack_cnt, ce_low); end
    $display("ignored io-tag/cyc=0 cycles: acks=%0d ce_low=%0d", ack_cnt, ce_low);
  endtask

  task automatic test_back_to_back;
    logic [7:0] r0, r1; int l0, l1, acks;
    preload(19'h0A0A0, 8'h11);
    preload(19'h50505, 8'hEE);
    clr_mon(8'h00);
    bus_xfer(1'b0, 19'h0A0A0, 8'h00, 1'b0, r0, l0);
    acks = ack_cnt;
    bus_xfer(1'b0, 19'h50505, 8'h00, 1'b0, r1, l1);
    n_cmp++; if (r0 !== 8'h11 || r1 !== 8'hEE) begin n_bad++; $display("FAIL b2b_data: got %h %h, required 11 ee", r0, r1); end
    n_cmp++; if (l0 !== RD_LAT || l1 !== RD_LAT) begin n_bad++; $display("FAIL b2b_latency: got %0d %0d, required %0d", l0, l1, RD_LAT); end
    n_cmp++; if (acks !== 1 || ack_cnt !== 2) begin n_bad++; $display("FAIL b2b_ack_count: got %0d then %0d, required 1 then 2", acks, ack_cnt); end
    $display("back-to-back reads: %h %h lat %0d %0d", r0, r1, l0, l1);
  endtask

  task automatic test_abort;
    logic [7:0] prev, r; int lat;
    prev = dat_o;
    preload(19'h00777, ~prev);
    clr_mon(8'h00);
    cyc = 1; stb = 1; tga = 2'b00; we = 0; adr = 19'h00777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0 || ce_n !== 1'b1 || oe_n !== 1'b1 || dq_oe !== 1'b0) begin
      n_bad++; $display("FAIL abort_strobes: got ack=%b ce_n=%b oe_n=%b dq_oe=%b, required 0 1 1 0", ack, ce_n, oe_n, dq_oe);
    end
    n_cmp++; if (dat_o !== prev) begin n_bad++; $display("FAIL abort_data: got %h, required %h", dat_o, prev); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (ack_cnt !== 0) begin n_bad++; $display("FAIL abort_no_ack: got %0d, required 0", ack_cnt); end
    bus_xfer(1'b1, 19'h00778, 8'h96, 1'b0, r, lat);
    ref_mem[32'h778] = 8'h96;
    n_cmp++; if (lat !== WR_LAT || dev_mem[19'h778] !== 8'h96) begin n_bad++; $display("FAIL abort_followup_write: got lat=%0d mem=%h, required %0d 96", lat, dev_mem[19'h778], WR_LAT); end
    $display("abort: dat_o=%h ce_n=%b followup lat=%0d", dat_o, ce_n, lat);
  endtask

  task automatic test_random;
    logic [AW-1:0] pool [8];
    logic [AW-1:0] a; logic [7:0] d, r, exp; logic w; int lat;
    for (int i = 0; i < 8; i++) begin
      pool[i] = AW'(32'h60000 + i * 3 + 1);
      preload(pool[i], 8'($urandom));
    end
    for (int i = 0; i < 24; i++) begin
      a = pool[$urandom_range(0, 7)];
      d = 8'($urandom);
      w = 1'($urandom);
      clr_mon(d);
      bus_xfer(w, a, d, 1'b1, r, lat);
      if (w) begin
        ref_mem[int'(a)] = d;
        n_cmp++;
        if (lat !== WR_LAT || we_low !== WWR || dq_bad !== 0) begin
          n_bad++; $display("FAIL rand_write[%0d]: got lat=%0d we_low=%0d dq_bad=%0d, required %0d %0d 0", i, lat, we_low, dq_bad, WR_LAT, WWR);
        end
      end else begin
        exp = ref_mem[int'(a)];
        n_cmp++;
        if (lat !== RD_LAT || r !== exp) begin
          n_bad++; $display("FAIL rand_read[%0d]: got lat=%0d data=%h, required %0d %h", i, lat, r, RD_LAT, exp);
        end
      end
      $display("rand %0d: %s a=%h d=%h r=%h lat=%0d", i, w ? "wr" : "rd", a, d, r, lat);
    end
  endtask

  task automatic test_reset_mid_write;
    int acks;
    clr_mon(8'hC3);
    cyc = 1; stb = 1; tga = 2'b00; we = 1; adr = 19'h00999; dat_i = 8'hC3;
    @(posedge clk); #1;
    @(posedge clk); #2;
    nrst = 0; #1;
    n_cmp++; if (we_n !== 1'b1 || ce_n !== 1'b1 || dq_oe !== 1'b0 || ack !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_write: got we_n=%b ce_n=%b dq_oe=%b ack=%b, required 1 1 0 0", we_n, ce_n, dq_oe, ack);
    end
    cyc = 0; stb = 0;
    @(posedge clk); #1; nrst = 1;
    acks = ack_cnt;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (ack_cnt !== acks || ack_cnt !== 0) begin n_bad++; $display("FAIL reset_no_ack: got %0d acks, required 0", ack_cnt); end
    $display("reset during write: we_n=%b ce_n=%b acks=%0d", we_n, ce_n, ack_cnt);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) dev_mem[i] = 8'h00;
    clr_mon(8'h00);
    test_reset;
    test_read;
    test_write;
    test_ignored;
    test_back_to_back;
    test_abort;
    test_random;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
